// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I load/store unit. It accepts one memory operation at a time from the
// execute stage, checks it for legality and alignment, presents a
// single-outstanding request to data memory, and then extracts and extends
// the loaded value.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   valid_in, is_load_in,   request from execute: kind, RV32I funct3 code,
//   is_store_in, funct3_in, effective address and rs2 value
//   addr_in, store_data_in
//   ready_out               high only while idle
//   dmem_*_out              registered request, word address, lane data, strobes
//   dmem_ack_in, dmem_rdata_in  memory completion and read word
//   load_data_out           extended load result, held until the next load
//   done_out, fault_out     one-cycle completion / fault pulses
//   fault_code_out          01 misaligned, 10 illegal, 11 timeout (held)
module load_store_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        ready_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wstrb_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] load_data_out,
  output logic        done_out,
  output logic        fault_out,
  output logic [1:0]  fault_code_out
);

  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_count;
  logic [2:0]  op_funct3;
  logic [1:0]  op_offset;

  logic        load_req;
  logic        store_req;
  logic        both_req;
  logic        funct3_ok;
  logic        misaligned;

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  store_strobe = 4'b0001 << off;
      3'b001:  store_strobe = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  store_strobe = 4'b1111;
      default: store_strobe = 4'b0000;
    endcase
  endfunction

  // Replicate the store operand so every enabled lane carries it.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      3'b000:  store_lanes = {4{data[7:0]}};
      3'b001:  store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  // Bring the addressed byte/halfword down to bit 0, then extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_extract = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_extract = {24'h000000, shifted[7:0]};
      3'b101:  load_extract = {16'h0000, shifted[15:0]};
      default: load_extract = shifted;
    endcase
  endfunction

  // Request decode: kind, funct3 legality for that kind, and alignment.
  always_comb begin
    both_req  = valid_in & is_load_in & is_store_in;
    load_req  = valid_in & is_load_in & ~is_store_in;
    store_req = valid_in & is_store_in & ~is_load_in;
    funct3_ok = 1'b0;
    misaligned = 1'b0;
    case (funct3_in)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = load_req;
      default:                funct3_ok = 1'b0;
    endcase
    // funct3[1:0] encodes access size for every legal code.
    case (funct3_in[1:0])
      2'b01:   misaligned = addr_in[0];
      2'b10:   misaligned = |addr_in[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign ready_out = (state == IDLE);

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      wait_count     <= 8'd0;
      op_funct3      <= 3'b000;
      op_offset      <= 2'b00;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= 32'h0000_0000;
      dmem_wdata_out <= 32'h0000_0000;
      dmem_wstrb_out <= 4'b0000;
      load_data_out  <= 32'h0000_0000;
      done_out       <= 1'b0;
      fault_out      <= 1'b0;
      fault_code_out <= 2'b00;
    end else begin
      done_out  <= 1'b0;
      fault_out <= 1'b0;
      case (state)
        IDLE: begin
          if (both_req) begin
            fault_out      <= 1'b1;
            fault_code_out <= 2'b10;
          end else if (load_req || store_req) begin
            if (!funct3_ok) begin
              fault_out      <= 1'b1;
              fault_code_out <= 2'b10;
            end else if (misaligned) begin
              fault_out      <= 1'b1;
              fault_code_out <= 2'b01;
            end else begin
              state          <= WAIT;
              wait_count     <= 8'd0;
              op_funct3      <= funct3_in;
              op_offset      <= addr_in[1:0];
              dmem_req_out   <= 1'b1;
              dmem_we_out    <= store_req;
              dmem_addr_out  <= {addr_in[31:2], 2'b00};
              dmem_wdata_out <= store_req ? store_lanes(funct3_in, store_data_in) : 32'h0000_0000;
              dmem_wstrb_out <= store_req ? store_strobe(funct3_in, addr_in[1:0]) : 4'b0000;
            end
          end
        end
        WAIT: begin
          // An ack in the final permitted cycle takes priority over the timeout.
          if (dmem_ack_in) begin
            state        <= DONE;
            dmem_req_out <= 1'b0;
            done_out     <= 1'b1;
            if (!dmem_we_out) begin
              load_data_out <= load_extract(op_funct3, op_offset, dmem_rdata_in);
            end
          end else if (wait_count == LAST_WAIT) begin
            state          <= IDLE;
            dmem_req_out   <= 1'b0;
            fault_out      <= 1'b1;
            fault_code_out <= 2'b11;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          dmem_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives load/store traffic into load_store_unit (ACK_TIMEOUT=4), pushes the
// expected completion of each operation into a queue, and pops/compares it
// whenever the unit pulses done_out or fault_out.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        is_load_in;
  logic        is_store_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        ready_out;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wstrb_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic [31:0] load_data_out;
  logic        done_out;
  logic        fault_out;
  logic [1:0]  fault_code_out;

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [31:0] ldata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_load = 32'h0000_0000;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  load_store_unit #(.ACK_TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .is_load_in(is_load_in), .is_store_in(is_store_in), .funct3_in(funct3_in),
    .addr_in(addr_in), .store_data_in(store_data_in), .ready_out(ready_out),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_wstrb_out(dmem_wstrb_out), .dmem_ack_in(dmem_ack_in),
    .dmem_rdata_in(dmem_rdata_in), .load_data_out(load_data_out),
    .done_out(done_out), .fault_out(fault_out), .fault_code_out(fault_code_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000: begin
        case (a[1:0])
          2'd0:    return 4'b0001;
          2'd1:    return 4'b0010;
          2'd2:    return 4'b0100;
          default: return 4'b1000;
        endcase
      end
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000:  return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      3'b001:  return {sd[15:0], sd[15:0]};
      default: return sd;
    endcase
  endfunction

  // Scoreboard: every done/fault pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && (done_out || fault_out)) begin
      check_eq("pulse_exclusive", 32'(done_out & fault_out), 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, done_out, fault_out}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("pulse_kind", 32'(fault_out), 32'(mon_e.is_fault));
        if (mon_e.is_fault) check_eq("fault_code", 32'(fault_code_out), 32'(mon_e.code));
        else                check_eq("load_data", load_data_out, mon_e.ldata);
      end
    end
  end

  // Present one request for a single cycle; returns mid-cycle N+1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk_in);
    valid_in = 1'b1; is_load_in = ld; is_store_in = st;
    funct3_in = f3; addr_in = a; store_data_in = sd;
    @(negedge clk_in);
    valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
    addr_in = $urandom; store_data_in = $urandom;
  endtask

  // Legal access; ack arrives 'delay' cycles after the request rises.
  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int delay, input logic [31:0] rd);
    exp_t e;
    if (ld) last_load = model_load(f3, a, rd);
    e.is_fault = 1'b0; e.code = 2'b00; e.ldata = last_load;
    sb.push_back(e);
    issue(ld, !ld, f3, a, sd);
    check_eq("req_rise", 32'(dmem_req_out), 32'd1);
    check_eq("ready_busy", 32'(ready_out), 32'd0);
    check_eq("addr", dmem_addr_out, {a[31:2], 2'b00});
    check_eq("we", 32'(dmem_we_out), 32'(!ld));
    check_eq("wstrb", 32'(dmem_wstrb_out), ld ? 32'd0 : 32'(model_strb(f3, a)));
    if (!ld) check_eq("wdata", dmem_wdata_out, model_wdata(f3, sd));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_in);
      check_eq("req_hold", 32'(dmem_req_out), 32'd1);
      check_eq("addr_hold", dmem_addr_out, {a[31:2], 2'b00});
    end
    dmem_ack_in = 1'b1; dmem_rdata_in = rd;
    @(negedge clk_in);
    dmem_ack_in = 1'b0; dmem_rdata_in = $urandom;
    check_eq("done_pulse", 32'(done_out), 32'd1);
    check_eq("req_drop", 32'(dmem_req_out), 32'd0);
    check_eq("ready_in_done", 32'(ready_out), 32'd0);
    @(negedge clk_in);
    check_eq("ready_again", 32'(ready_out), 32'd1);
    check_eq("done_one_cycle", 32'(done_out), 32'd0);
  endtask

  // Request that must fault immediately without touching memory.
  task automatic bad_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] code);
    exp_t e;
    e.is_fault = 1'b1; e.code = code; e.ldata = 32'd0;
    sb.push_back(e);
    issue(ld, st, f3, a, 32'h1234_5678);
    check_eq("fault_pulse", 32'(fault_out), 32'd1);
    check_eq("fault_no_req", 32'(dmem_req_out), 32'd0);
    check_eq("fault_ready", 32'(ready_out), 32'd1);
    @(negedge clk_in);
    check_eq("fault_no_req_later", 32'(dmem_req_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] a;
    rst_in = 1'b0; valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
    funct3_in = 3'b000; addr_in = 32'd0; store_data_in = 32'd0;
    dmem_ack_in = 1'b0; dmem_rdata_in = 32'd0;
    #1;
    check_eq("rst_ready", 32'(ready_out), 32'd1);
    check_eq("rst_req", 32'(dmem_req_out), 32'd0);
    check_eq("rst_wstrb", 32'(dmem_wstrb_out), 32'd0);
    check_eq("rst_pulses", {30'd0, done_out, fault_out}, 32'd0);
    check_eq("rst_code", 32'(fault_code_out), 32'd0);
    check_eq("rst_ldata", load_data_out, 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;

    // Reference vectors.
    mem_op(1'b1, 3'b000, 32'h0000_1003, 32'd0, 0, 32'h80AA_BBCC);
    check_eq("lb_value", load_data_out, 32'hFFFF_FF80);
    mem_op(1'b1, 3'b101, 32'h0000_2002, 32'd0, 1, 32'h8001_1234);
    check_eq("lhu_value", load_data_out, 32'h0000_8001);
    mem_op(1'b1, 3'b001, 32'h0000_2002, 32'd0, 2, 32'h8001_1234);
    check_eq("lh_value", load_data_out, 32'hFFFF_8001);
    mem_op(1'b0, 3'b000, 32'h0000_0011, 32'hDEAD_BEA5, 0, 32'h5555_AAAA);
    check_eq("store_keeps_ldata", load_data_out, 32'hFFFF_8001);
    mem_op(1'b0, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 1, 32'd0);
    mem_op(1'b0, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 0, 32'd0);

    // Illegal and misaligned requests.
    bad_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 2'b01);
    bad_op(1'b1, 1'b0, 3'b001, 32'h0000_0005, 2'b01);
    bad_op(1'b1, 1'b0, 3'b011, 32'h0000_0000, 2'b10);
    bad_op(1'b0, 1'b1, 3'b100, 32'h0000_0000, 2'b10);
    bad_op(1'b1, 1'b1, 3'b000, 32'h0000_0000, 2'b10);

    // Neither kind set: ignored, and an idle ack is ignored too.
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0040, 32'd0);
    check_eq("ignore_no_req", 32'(dmem_req_out), 32'd0);
    dmem_ack_in = 1'b1;
    @(negedge clk_in);
    dmem_ack_in = 1'b0;
    check_eq("ignore_ready", 32'(ready_out), 32'd1);
    check_eq("code_hold", 32'(fault_code_out), 32'd2);
    mem_op(1'b0, 3'b000, 32'h0000_0043, 32'h0000_0077, 0, 32'd0);
    check_eq("code_hold_after_done", 32'(fault_code_out), 32'd2);

    // Timeout with no ack.
    e.is_fault = 1'b1; e.code = 2'b11; e.ldata = 32'd0;
    sb.push_back(e);
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0077, 32'd0);
    check_eq("tmo_req_rise", 32'(dmem_req_out), 32'd1);
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk_in);
      check_eq("tmo_req_hold", 32'(dmem_req_out), 32'd1);
    end
    @(negedge clk_in);
    check_eq("tmo_req_drop", 32'(dmem_req_out), 32'd0);
    check_eq("tmo_fault", 32'(fault_out), 32'd1);
    check_eq("tmo_ready", 32'(ready_out), 32'd1);
    check_eq("tmo_ldata_kept", load_data_out, last_load);

    // Ack in the last permitted cycle wins over timeout.
    mem_op(1'b1, 3'b010, 32'h0000_0050, 32'd0, TMO - 1, 32'hA5A5_5A5A);
    check_eq("late_ack_code_kept", 32'(fault_code_out), 32'd3);

    // Randomised legal traffic.
    for (int k = 0; k < 8; k++) begin
      f3 = ld_codes[$urandom_range(0, 4)];
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      mem_op(1'b1, f3, a, 32'd0, $urandom_range(0, TMO - 1), $urandom);
      f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if (f3 == 3'b001) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      mem_op(1'b0, f3, a, $urandom, $urandom_range(0, TMO - 1), $urandom);
    end

    // Reset in mid-WAIT abandons the access; a late ack is ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
    check_eq("rw_req_rise", 32'(dmem_req_out), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_eq("rw_req_clear", 32'(dmem_req_out), 32'd0);
    check_eq("rw_ready", 32'(ready_out), 32'd1);
    check_eq("rw_ldata_clear", load_data_out, 32'd0);
    last_load = 32'd0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("rw_ready_after", 32'(ready_out), 32'd1);
    dmem_ack_in = 1'b1; dmem_rdata_in = 32'hFFFF_FFFF;
    @(negedge clk_in);
    dmem_ack_in = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      check_eq("rw_no_done", 32'(done_out), 32'd0);
    end
    check_eq("rw_ldata_kept", load_data_out, 32'd0);

    mem_op(1'b1, 3'b010, 32'h0000_0100, 32'd0, 0, 32'h1234_5678);
    repeat (2) @(negedge clk_in);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
